// File: rtl/frame_burst_sched.sv
// Frame DMA command scheduler: splits each line into full bursts plus a tail,
// limits outstanding commands and reports in-order completions.
module frame_burst_sched #(
    parameter int ASIZE          = 29,
    parameter int BURST_MAP_ADDR = 12800,
    parameter int LSIZE          = 16,
    parameter int MAX_OUT        = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic [ASIZE-1:0] baseaddr,
    input  logic [ASIZE-1:0] line_stride,
    input  logic [LSIZE-1:0] line_bytes,
    input  logic [LSIZE-1:0] line_num,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [ASIZE-1:0] cmd_addr,
    output logic [LSIZE-1:0] cmd_len,
    input  logic             resp_valid,
    output logic             resp_ready,
    output logic             burst_done,
    output logic             tail_done,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [LSIZE-1:0] BLEN = LSIZE'(BURST_MAP_ADDR);
    localparam logic [3:0]       MAXO = 4'(MAX_OUT);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state, state_n;
    logic [ASIZE-1:0]   line_start, stride;
    logic [LSIZE-1:0]   rem, lbytes, lines_left;
    logic [3:0]         outstanding, wr_idx;
    logic [MAX_OUT-1:0] fifo, fifo_n;
    logic               resp_prev;
    logic               cmd_hs, resp_hs, cmd_full;
    logic               line_end, last_cmd, start_zero;

    assign cmd_full   = rem >= BLEN;
    assign cmd_len    = cmd_full ? BLEN : rem;
    assign cmd_valid  = (state == ISSUE) && (outstanding < MAXO);
    assign cmd_hs     = cmd_valid && cmd_ready;
    assign resp_ready = (outstanding != 4'd0) && !resp_prev;
    assign resp_hs    = resp_valid && resp_ready;
    assign line_end   = rem == cmd_len;
    assign last_cmd   = line_end && (lines_left == LSIZE'(1));
    assign start_zero = (line_num == '0) || (line_bytes == '0);
    assign busy       = state != IDLE;
    assign frame_done = state == DONE;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = start_zero ? DONE : ISSUE;
            ISSUE:   if (cmd_hs && last_cmd) state_n = DRAIN;
            DRAIN:   if (outstanding == 4'd0) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Shift-out FIFO of command kinds: entry 0 is the oldest outstanding one.
    always_comb begin
        wr_idx = outstanding - {3'b000, resp_hs};
        fifo_n = resp_hs ? (fifo >> 1) : fifo;
        for (int i = 0; i < MAX_OUT; i++) begin
            if (cmd_hs && (4'(i) == wr_idx)) fifo_n[i] = cmd_full;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= IDLE;
            outstanding <= '0;
            fifo        <= '0;
            resp_prev   <= 1'b0;
            burst_done  <= 1'b0;
            tail_done   <= 1'b0;
            cmd_addr    <= '0;
            line_start  <= '0;
            stride      <= '0;
            rem         <= '0;
            lbytes      <= '0;
            lines_left  <= '0;
        end else begin
            state      <= state_n;
            fifo       <= fifo_n;
            resp_prev  <= resp_hs;
            burst_done <= resp_hs && fifo[0];
            tail_done  <= resp_hs && !fifo[0];
            if (cmd_hs && !resp_hs) outstanding <= outstanding + 4'd1;
            else if (!cmd_hs && resp_hs) outstanding <= outstanding - 4'd1;
            if (state == IDLE && start) begin
                cmd_addr   <= baseaddr;
                line_start <= baseaddr;
                stride     <= line_stride;
                lbytes     <= line_bytes;
                lines_left <= line_num;
                rem        <= start_zero ? '0 : line_bytes;
            end else if (cmd_hs) begin
                if (line_end) begin
                    cmd_addr   <= line_start + stride;
                    line_start <= line_start + stride;
                    lines_left <= lines_left - LSIZE'(1);
                    rem        <= last_cmd ? '0 : lbytes;
                end else begin
                    cmd_addr <= cmd_addr + ASIZE'(cmd_len);
                    rem      <= rem - cmd_len;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_burst_sched.sv
// Randomised and directed bench for frame_burst_sched against a
// command-list reference model built from the frame geometry.
module tb_frame_burst_sched;

    localparam int ASIZE = 29;
    localparam int B     = 12800;
    localparam int LSIZE = 16;
    localparam int MAXO  = 4;

    typedef struct {
        logic [ASIZE-1:0] a;
        logic [LSIZE-1:0] l;
    } cmd_t;

    logic             clock = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [ASIZE-1:0] baseaddr = '0;
    logic [ASIZE-1:0] line_stride = '0;
    logic [LSIZE-1:0] line_bytes = '0;
    logic [LSIZE-1:0] line_num = '0;
    logic             cmd_ready = 1'b0;
    logic             resp_valid = 1'b0;
    logic             cmd_valid, resp_ready, burst_done, tail_done;
    logic             busy, frame_done;
    logic [ASIZE-1:0] cmd_addr;
    logic [LSIZE-1:0] cmd_len;

    frame_burst_sched #(
        .ASIZE(ASIZE), .BURST_MAP_ADDR(B), .LSIZE(LSIZE), .MAX_OUT(MAXO)
    ) dut (
        .clock(clock), .rst(rst), .start(start),
        .baseaddr(baseaddr), .line_stride(line_stride),
        .line_bytes(line_bytes), .line_num(line_num),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .burst_done(burst_done), .tail_done(tail_done),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // rdy_mode: 0 low, 1 high, 2 random. rv_mode: 0 low, 1 random, 2 high, 3 one-shot.
    int rdy_mode = 1;
    int rv_mode  = 0;

    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            0:       cmd_ready = 1'b0;
            1:       cmd_ready = 1'b1;
            default: cmd_ready = ($urandom_range(0, 3) != 0);
        endcase
        case (rv_mode)
            0:       resp_valid = 1'b0;
            2:       resp_valid = 1'b1;
            3: begin resp_valid = 1'b1; rv_mode = 0; end
            default: resp_valid = ($urandom_range(0, 2) == 0);
        endcase
    end

    // Reference model: the expected command list of a frame, the kinds of
    // accepted but unanswered commands, and a coarse idle/run/done phase.
    cmd_t q[$];
    bit   tq[$];
    cmd_t log_q[$];
    int   mout = 0;
    bit   prev_hs = 0;
    bit   e_bd = 0, e_td = 0;
    int   phase = 0;
    bit   armed = 0;
    int   bd_cnt = 0, td_cnt = 0, fd_cnt = 0;

    function automatic void build(input logic [ASIZE-1:0] b, input logic [ASIZE-1:0] s,
                                  input int lb, input int ln);
        for (int l = 0; l < ln; l++) begin
            for (int off = 0; off < lb; off += B) begin
                cmd_t   c;
                longint a;
                a   = longint'(b) + longint'(l) * longint'(s) + longint'(off);
                c.a = a[ASIZE-1:0];
                c.l = LSIZE'((lb - off >= B) ? B : lb - off);
                q.push_back(c);
            end
        end
    endfunction

    always @(negedge clock) begin
        bit cv, rr, chs, rhs, drained;
        cv = (phase == 1) && (q.size() > 0) && (mout < MAXO);
        rr = (mout > 0) && !prev_hs;
        if (armed) begin
            chk("cmd_valid", 64'(cmd_valid), 64'(cv));
            chk("resp_ready", 64'(resp_ready), 64'(rr));
            chk("busy", 64'(busy), 64'(phase != 0));
            chk("frame_done", 64'(frame_done), 64'(phase == 2));
            chk("burst_done", 64'(burst_done), 64'(e_bd));
            chk("tail_done", 64'(tail_done), 64'(e_td));
            if (cv) begin
                chk("cmd_addr", 64'(cmd_addr), 64'(q[0].a));
                chk("cmd_len", 64'(cmd_len), 64'(q[0].l));
            end
            if (burst_done === 1'b1) bd_cnt++;
            if (tail_done === 1'b1) td_cnt++;
            if (frame_done === 1'b1) fd_cnt++;
        end
        chs = cv && cmd_ready;
        rhs = rr && resp_valid;
        drained = (phase == 1) && (q.size() == 0) && (mout == 0);
        if (rst) begin
            q.delete();
            tq.delete();
            mout = 0; prev_hs = 0; e_bd = 0; e_td = 0; phase = 0;
            armed = 1;
        end else begin
            e_bd = rhs && tq[0];
            e_td = rhs && !tq[0];
            if (rhs) void'(tq.pop_front());
            if (chs) begin
                tq.push_back(q[0].l == LSIZE'(B));
                log_q.push_back(q[0]);
                void'(q.pop_front());
            end
            mout = mout + int'(chs) - int'(rhs);
            prev_hs = rhs;
            case (phase)
                0: if (start) begin
                    if (line_num == '0 || line_bytes == '0) phase = 2;
                    else begin
                        build(baseaddr, line_stride, int'(line_bytes), int'(line_num));
                        phase = 1;
                    end
                end
                1: if (drained) phase = 2;
                default: phase = 0;
            endcase
        end
    end

    task automatic launch(input logic [ASIZE-1:0] b, input logic [ASIZE-1:0] s,
                          input int lb, input int ln, input int rm, input int vm);
        @(posedge clock); #1;
        baseaddr    = b;
        line_stride = s;
        line_bytes  = LSIZE'(lb);
        line_num    = LSIZE'(ln);
        rdy_mode    = rm;
        rv_mode     = vm;
        start       = 1'b1;
        @(posedge clock); #1;
        start       = 1'b0;
        baseaddr    = ASIZE'($urandom);
        line_stride = ASIZE'($urandom);
        line_bytes  = LSIZE'($urandom);
        line_num    = LSIZE'($urandom);
    endtask

    task automatic wait_frame(input int f0, input int budget);
        for (int i = 0; i < budget && fd_cnt == f0; i++) @(posedge clock);
        chk("frame_end_within_budget", 64'(fd_cnt != f0), 64'd1);
        repeat (3) @(posedge clock);
    endtask

    task automatic run_frame(input logic [ASIZE-1:0] b, input logic [ASIZE-1:0] s,
                             input int lb, input int ln, input int rm, input int vm,
                             input bit stray);
        int f0;
        f0 = fd_cnt;
        launch(b, s, lb, ln, rm, vm);
        if (stray) begin
            repeat (2) @(posedge clock);
            #1; line_num = '0; start = 1'b1;
            @(posedge clock); #1; start = 1'b0;
        end
        wait_frame(f0, 3000);
    endtask

    task automatic clear_counts();
        log_q.delete();
        bd_cnt = 0; td_cnt = 0; fd_cnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
        chk({tag, "_cmd_addr"}, 64'(cmd_addr), 64'd0);
        chk({tag, "_cmd_len"}, 64'(cmd_len), 64'd0);
        chk({tag, "_resp_ready"}, 64'(resp_ready), 64'd0);
        chk({tag, "_burst_done"}, 64'(burst_done), 64'd0);
        chk({tag, "_tail_done"}, 64'(tail_done), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_a[6];
        int f0, n0, waited;
        exp_a = '{32'h1000, 32'h4200, 32'h7400, 32'h9000, 32'hC200, 32'hF400};

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset");
        @(posedge clock); #1;
        rst = 1'b0;

        // Two-line frame with bursts and tails, responses as fast as allowed.
        clear_counts();
        run_frame(29'h1000, 29'd32768, 30000, 2, 1, 2, 1'b0);
        chk("f35_ncmd", 64'(log_q.size()), 64'd6);
        for (int i = 0; i < 6 && i < log_q.size(); i++) begin
            chk($sformatf("f35_addr%0d", i), 64'(log_q[i].a), 64'(exp_a[i]));
            chk($sformatf("f35_len%0d", i), 64'(log_q[i].l),
                (i % 3 == 2) ? 64'd4400 : 64'd12800);
        end
        chk("f35_bursts", 64'(bd_cnt), 64'd4);
        chk("f35_tails", 64'(td_cnt), 64'd2);
        chk("f35_frames", 64'(fd_cnt), 64'd1);

        // Exact multiple of the burst size: no tail.
        clear_counts();
        run_frame(29'h20, 29'd0, 25600, 1, 1, 2, 1'b0);
        chk("mult_ncmd", 64'(log_q.size()), 64'd2);
        chk("mult_tails", 64'(td_cnt), 64'd0);
        chk("mult_bursts", 64'(bd_cnt), 64'd2);

        // Outstanding limit, then a single response frees one slot.
        clear_counts();
        f0 = fd_cnt;
        launch(29'h0, 29'd0, 5 * B, 1, 1, 0);
        repeat (20) @(posedge clock);
        @(negedge clock);
        chk("limit_ncmd", 64'(log_q.size()), 64'd4);
        chk("limit_cmd_valid", 64'(cmd_valid), 64'd0);
        @(posedge clock); #1;
        rv_mode = 3;
        repeat (10) @(posedge clock);
        @(negedge clock);
        chk("limit_one_more", 64'(log_q.size()), 64'd5);
        chk("limit_one_burst", 64'(bd_cnt), 64'd1);
        @(posedge clock); #1;
        rv_mode = 2;
        wait_frame(f0, 200);
        chk("limit_bursts", 64'(bd_cnt), 64'd5);

        // Address wrap modulo 2^ASIZE with a negative stride.
        clear_counts();
        run_frame(29'h1FFFFF00, 29'h1FFFFFC0, 13000, 3, 2, 1, 1'b0);
        chk("wrap_ncmd", 64'(log_q.size()), 64'd6);
        if (log_q.size() > 2) begin
            chk("wrap_addr1", 64'(log_q[1].a), 64'h3100);
            chk("wrap_addr2", 64'(log_q[2].a), 64'h1FFFFEC0);
        end

        // Zero line count: immediate done, no commands.
        clear_counts();
        run_frame(29'h100, 29'd0, 500, 0, 1, 1, 1'b0);
        chk("zero_ncmd", 64'(log_q.size()), 64'd0);

        // Random frames under random back-pressure; stray starts must be ignored.
        for (int k = 0; k < 16; k++) begin
            int lb, ln;
            lb = ($urandom_range(0, 3) == 0) ? B * $urandom_range(1, 5)
                                             : $urandom_range(1, 40000);
            ln = $urandom_range(1, 3);
            run_frame(ASIZE'($urandom),
                      ($urandom_range(0, 1) == 0) ? ASIZE'($urandom) : ASIZE'(65536),
                      lb, ln, 2, 1, k[0]);
        end

        // Reset in the middle of a frame with responses pending.
        clear_counts();
        launch(29'h1000, 29'd32768, 30000, 2, 1, 0);
        for (int i = 0; i < 20 && log_q.size() < 2; i++) @(posedge clock);
        #1;
        rst = 1'b1;
        rv_mode = 2;
        @(posedge clock);
        @(negedge clock);
        check_reset_outputs("midrst");
        @(posedge clock); #1;
        rst = 1'b0;
        repeat (5) @(posedge clock);
        n0 = log_q.size();
        f0 = fd_cnt;
        #1;
        line_num = '0; line_bytes = LSIZE'(100); start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        waited = 0;
        while (fd_cnt == f0 && waited < 4) begin
            @(posedge clock);
            waited++;
        end
        chk("zero_after_rst_done", 64'(fd_cnt - f0), 64'd1);
        chk("zero_after_rst_ncmd", 64'(log_q.size() - n0), 64'd0);
        repeat (4) @(posedge clock);
        chk("zero_after_rst_pulses", 64'(bd_cnt + td_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
